decoder_scan: RTL and testbench

DECODER_SCAN -- requirements
Module: decoder_scan

---
 rtl/decoder_pkg.sv | 19 +
 rtl/dwell_counter.sv | 32 +++
 rtl/decoder_scan.sv | 105 ++++++++++
 tb/tb_decoder_scan.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared types and default parameter values for the decoder scan block.
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam int DEF_SEL_W      = 4;
    localparam int DEF_DWELL      = 4;
    localparam bit DEF_ACTIVE_LOW = 1'b0;

    // A DWELL of 1 still needs a one-bit counter.
    function automatic int cnt_width(input int dwell);
        return (dwell > 1) ? $clog2(dwell) : 1;
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// Counts 0..DWELL-1 while enabled; o_tc flags the last cycle of a dwell period.
module dwell_counter
    import decoder_pkg::*;
#(
    parameter int DWELL = DEF_DWELL
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc
);

    localparam int                CNT_W = cnt_width(DWELL);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] r_count;

    assign o_tc = (r_count == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= o_tc ? '0 : r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/decoder_scan.sv
// Registered one-hot decoder with direct-select and auto-scan modes.
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int SEL_W      = DEF_SEL_W,
    parameter int DWELL      = DEF_DWELL,
    parameter bit ACTIVE_LOW = DEF_ACTIVE_LOW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      select,
    output logic [2**SEL_W-1:0]   decoded,
    output logic [SEL_W-1:0]      index,
    output logic                  wrap
);

    localparam int              OUTS     = 2**SEL_W;
    localparam logic [OUTS-1:0] INACTIVE = {OUTS{ACTIVE_LOW}};

    state_t            r_state;
    state_t            w_next_state;
    logic [OUTS-1:0]   r_decoded;
    logic [SEL_W-1:0]  r_index;
    logic              r_wrap;

    logic              w_scanning;
    logic              w_tc;
    logic              w_active;
    logic [SEL_W-1:0]  w_index_nxt;
    logic              w_wrap_nxt;
    logic [OUTS-1:0]   w_decoded_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Every state reacts identically to the inputs, so the next state depends on them alone.
    always_comb begin
        w_next_state = IDLE;
        if (enable) begin
            w_next_state = mode ? SCAN : DIRECT;
        end
    end

    // The dwell count only survives while staying in SCAN; any other path restarts it.
    assign w_scanning = (r_state == SCAN) && (w_next_state == SCAN);

    dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (!w_scanning),
        .i_enable (w_scanning),
        .o_tc     (w_tc)
    );

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_index_nxt = r_index;
        w_wrap_nxt  = 1'b0;
        w_active    = 1'b0;
        unique case (w_next_state)
            DIRECT: begin
                w_index_nxt = select;
                w_active    = 1'b1;
            end
            SCAN: begin
                w_active = 1'b1;
                if (r_state != SCAN) begin
                    w_index_nxt = select;
                end else if (w_tc) begin
                    w_index_nxt = r_index + SEL_W'(1);
                    w_wrap_nxt  = (r_index == '1);
                end
            end
            default: begin
            end
        endcase
        w_decoded_nxt = (w_active ? (OUTS'(1) << w_index_nxt) : '0) ^ INACTIVE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_decoded <= INACTIVE;
            r_index   <= '0;
            r_wrap    <= 1'b0;
        end else begin
            r_decoded <= w_decoded_nxt;
            r_index   <= w_index_nxt;
            r_wrap    <= w_wrap_nxt;
        end
    end

    assign decoded = r_decoded;
    assign index   = r_index;
    assign wrap    = r_wrap;

endmodule

// File: tb/tb_decoder_scan.sv
// Directed bench for decoder_scan: three instances (DWELL=4, DWELL=2, DWELL=1 active-low).
module tb_decoder_scan;

    typedef struct {
        int          dut;
        string       tag;
        logic [15:0] dec;
        logic [3:0]  idx;
        logic        wrp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en   [3];
    logic        md   [3];
    logic [3:0]  sel  [3];
    logic [15:0] dec0, dec1, dec2;
    logic [3:0]  idx0, idx1, idx2;
    logic        wrp0, wrp1, wrp2;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    decoder_scan #(.SEL_W(4), .DWELL(4), .ACTIVE_LOW(1'b0)) u_d4 (
        .clk(clk), .reset(rst), .enable(en[0]), .mode(md[0]), .select(sel[0]),
        .decoded(dec0), .index(idx0), .wrap(wrp0));

    decoder_scan #(.SEL_W(4), .DWELL(2), .ACTIVE_LOW(1'b0)) u_d2 (
        .clk(clk), .reset(rst), .enable(en[1]), .mode(md[1]), .select(sel[1]),
        .decoded(dec1), .index(idx1), .wrap(wrp1));

    decoder_scan #(.SEL_W(4), .DWELL(1), .ACTIVE_LOW(1'b1)) u_al (
        .clk(clk), .reset(rst), .enable(en[2]), .mode(md[2]), .select(sel[2]),
        .decoded(dec2), .index(idx2), .wrap(wrp2));

    function automatic logic [15:0] dec_of(input int d);
        case (d)
            0:       return dec0;
            1:       return dec1;
            default: return dec2;
        endcase
    endfunction

    function automatic logic [3:0] idx_of(input int d);
        case (d)
            0:       return idx0;
            1:       return idx1;
            default: return idx2;
        endcase
    endfunction

    function automatic logic wrp_of(input int d);
        case (d)
            0:       return wrp0;
            1:       return wrp1;
            default: return wrp2;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int d, input string tag, input logic [15:0] dv,
                        input logic [3:0] iv, input logic wv);
        exp_t e;
        e.dut = d; e.tag = tag; e.dec = dv; e.idx = iv; e.wrp = wv;
        sb.push_back(e);
    endtask

    // One clock edge, then compare everything expected for that edge.
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("%s_dec", e.tag), 32'(dec_of(e.dut)), 32'(e.dec));
            check($sformatf("%s_idx", e.tag), 32'(idx_of(e.dut)), 32'(e.idx));
            check($sformatf("%s_wrap", e.tag), 32'(wrp_of(e.dut)), 32'(e.wrp));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  walk     [8];
        logic [15:0] walk_exp [8];
        logic [15:0] prev;
        logic [3:0]  ei;

        walk     = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd11, 4'd15, 4'd0};
        walk_exp = '{16'h0001, 16'h0002, 16'h0004, 16'h0008,
                     16'h0010, 16'h0800, 16'h8000, 16'h0001};

        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            en[d] = 1'b1; md[d] = 1'b0; sel[d] = 4'd5;
        end

        // Reset held for three edges with enable high.
        for (int c = 0; c < 3; c++) begin
            push(0, "rst_d4", 16'h0000, 4'd0, 1'b0);
            push(2, "rst_al", 16'hFFFF, 4'd0, 1'b0);
            cycle();
        end
        rst = 1'b0;

        // Direct walk: each select held two cycles, one cycle of latency.
        prev = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            sel[0] = walk[i];
            #1;
            check("dir_latency", 32'(dec0), 32'(prev));
            push(0, "dir_a", walk_exp[i], walk[i], 1'b0);
            cycle();
            push(0, "dir_b", walk_exp[i], walk[i], 1'b0);
            cycle();
            prev = walk_exp[i];
        end

        // DWELL=2 scan from 14 across the wrap; select change mid-scan is ignored.
        md[1]  = 1'b1;
        sel[1] = 4'd14;
        for (int k = 0; k < 9; k++) begin
            if (k == 2) sel[1] = 4'd3;
            ei = 4'(14 + k / 2);
            push(1, "scan2", 16'h0001 << ei, ei, (k == 4));
            cycle();
        end

        // DWELL=1 active-low scan from 0, through two wraps, then disable.
        md[2]  = 1'b1;
        sel[2] = 4'd0;
        for (int k = 0; k < 34; k++) begin
            ei = 4'(k);
            push(2, "al_scan", ~(16'h0001 << ei), ei, (k > 0) && (ei == 4'd0));
            cycle();
        end
        en[2] = 1'b0;
        push(2, "al_off", 16'hFFFF, 4'd1, 1'b0);
        cycle();

        // DWELL=4 scan from 4 until index=7 with one dwell cycle elapsed.
        md[0]  = 1'b1;
        sel[0] = 4'd4;
        for (int k = 0; k < 14; k++) begin
            if (k == 1) sel[0] = 4'd9;
            ei = 4'(4 + k / 4);
            push(0, "scan4", 16'h0001 << ei, ei, 1'b0);
            cycle();
        end

        // Asynchronous reset between edges clears outputs immediately.
        #2;
        rst = 1'b1;
        #1;
        check("arst_dec", 32'(dec0), 32'h0);
        check("arst_idx", 32'(idx0), 32'h0);
        check("arst_wrap", 32'(wrp0), 32'h0);
        check("arst_al_dec", 32'(dec2), 32'hFFFF);
        check("arst_al_idx", 32'(idx2), 32'h0);
        #1;
        rst = 1'b0;

        // Scan restarts at select=9 after release; stop mid-dwell at index 10.
        for (int k = 0; k < 6; k++) begin
            ei = 4'(9 + k / 4);
            push(0, "rescan", 16'h0001 << ei, ei, 1'b0);
            cycle();
        end

        // Mode toggle mid-dwell: one DIRECT cycle, then a fresh full dwell.
        md[0]  = 1'b0;
        sel[0] = 4'd2;
        push(0, "tog_dir", 16'h0004, 4'd2, 1'b0);
        cycle();
        md[0]  = 1'b1;
        sel[0] = 4'd6;
        for (int k = 0; k < 5; k++) begin
            ei = 4'(6 + k / 4);
            push(0, "tog_scan", 16'h0001 << ei, ei, 1'b0);
            cycle();
        end

        en[0] = 1'b0;
        push(0, "idle_d4", 16'h0000, 4'd7, 1'b0);
        cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
